// File: rtl/led_pwm_fader.sv
// led_pwm_fader: two-channel LED fader, ramps PWM brightness up/down toward the on/off pattern from led_in.
module led_pwm_fader #(
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 781_250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] led_in,
  output logic [1:0] led_out,
  output logic       fading
);
  localparam logic [PWM_W-1:0] MAX = '1;
  localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_t;
  logic [1:0]             led_q;
  logic [SW-1:0]          step_cnt;
  logic                   step_tick;
  logic [PWM_W-1:0]       pwm_cnt;
  logic [1:0][PWM_W-1:0]  level;
  state_t                 state [2];
  assign step_tick = step_cnt == STEP_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      level    <= '0;
      led_out  <= '0;
      fading   <= 1'b0;
      for (int i = 0; i < 2; i++) state[i] <= OFF;
    end else begin
      led_q    <= led_in;
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt == MAX - 1'b1 ? '0 : pwm_cnt + 1'b1;
      fading   <= state[0] == UP || state[0] == DOWN || state[1] == UP || state[1] == DOWN;
      for (int i = 0; i < 2; i++) begin
        led_out[i] <= level[i] > pwm_cnt;
        // a direction change wins over a coincident step, so level never jumps
        case (state[i])
          OFF: begin
            level[i] <= '0;
            if (led_q[i]) state[i] <= UP;
          end
          UP:
            if (!led_q[i]) state[i] <= DOWN;
            else if (step_tick) begin
              level[i] <= level[i] == MAX ? MAX : level[i] + 1'b1;
              state[i] <= level[i] >= MAX - 1'b1 ? ON : UP;
            end
          ON: begin
            level[i] <= MAX;
            if (!led_q[i]) state[i] <= DOWN;
          end
          DOWN:
            if (led_q[i]) state[i] <= UP;
            else if (step_tick) begin
              level[i] <= level[i] == '0 ? '0 : level[i] - 1'b1;
              state[i] <= level[i] <= PWM_W'(1) ? OFF : DOWN;
            end
          default: state[i] <= OFF;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed checks of reset, ramps, duty, reversal, crossfade and mid-ramp reset (MAX=15, STEP_DIV=4).
module tb_led_pwm_fader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] led_in = 2'b00;
  logic [1:0] led_out;
  logic       fading;
  int n_tests = 0;
  int n_fail  = 0;

  led_pwm_fader #(.PWM_W(4), .STEP_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .led_in(led_in),
    .led_out(led_out),
    .fading(fading)
  );

  always #5 clk = ~clk;

  function automatic int lvl(input int ch);
    return int'(dut.level[ch]);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_lvl(input int ch, input int v, input string tag);
    int k = 0;
    while (lvl(ch) != v && k < 200) begin
      cyc(1);
      k++;
    end
    check({tag, "_reached"}, lvl(ch), v);
  endtask

  initial begin
    int act, fcnt, jumps, prev, mid, h0, h1, cnt, mx, bad, conc, s;
    led_in = 2'b11;
    rst = 1'b1;
    cyc(1);
    check("rst_out_a", led_out, 0);
    check("rst_fade_a", fading, 0);
    cyc(1);
    check("rst_out_b", led_out, 0);
    check("rst_fade_b", fading, 0);
    rst = 1'b0;
    cyc(1);
    check("post_rst_out", led_out, 0);
    check("post_rst_fade", fading, 0);

    led_in = 2'b00;
    do_reset();
    act = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      act += int'(led_out != 2'b00 || fading);
    end
    check("idle_quiet", act, 0);

    do_reset();
    led_in = 2'b01;
    fcnt = 0; jumps = 0; prev = 0; mid = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      fcnt += int'(fading);
      if (lvl(0) < prev || lvl(0) - prev > 1) jumps++;
      prev = lvl(0);
      if (i == 20) mid = int'(fading);
    end
    check("up_level", lvl(0), 15);
    check("up_jumps", jumps, 0);
    check("up_fade_mid", mid, 1);
    check("up_fade_len_ok", int'(fcnt >= 56 && fcnt <= 64), 1);
    check("up_fade_end", fading, 0);
    h0 = 0; h1 = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      h0 += int'(led_out[0]);
      h1 += int'(led_out[1]);
    end
    check("up_out0_const", h0, 30);
    check("up_out1_zero", h1, 0);

    do_reset();
    led_in = 2'b01;
    wait_lvl(0, 8, "duty");
    h0 = 0; h1 = 0;
    for (int i = 0; i < 50; i++) begin
      led_in[0] = ~led_in[0];
      cyc(1);
      if (i >= 20 && i < 35) h0 += int'(led_out[0]);
      if (i >= 35) h1 += int'(led_out[0]);
    end
    check("duty_win1", h0, 8);
    check("duty_win2", h1, 8);
    check("duty_level", lvl(0), 8);

    do_reset();
    led_in = 2'b01;
    wait_lvl(0, 5, "rev");
    led_in = 2'b00;
    cnt = 0; mx = 0; jumps = 0; prev = 5;
    while (lvl(0) != 0 && cnt < 100) begin
      cyc(1);
      cnt++;
      if (lvl(0) > mx) mx = lvl(0);
      if (lvl(0) > prev || prev - lvl(0) > 1) jumps++;
      prev = lvl(0);
    end
    check("rev_max", mx, 5);
    check("rev_jumps", jumps, 0);
    check("rev_cycles", cnt, 20);
    cyc(3);
    check("rev_state_off", int'(dut.state[0]), 0);
    check("rev_out0", led_out[0], 0);
    check("rev_fade", fading, 0);

    do_reset();
    led_in = 2'b01;
    wait_lvl(0, 15, "xf");
    cyc(3);
    led_in = 2'b10;
    bad = 0; mid = 0; conc = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      s = lvl(0) + lvl(1);
      if (s < 14 || s > 16) bad++;
      if (i == 30) begin
        mid = int'(fading);
        conc = int'(lvl(0) > 0 && lvl(0) < 15 && lvl(1) > 0 && lvl(1) < 15);
      end
    end
    check("xf_sum", bad, 0);
    check("xf_fade_mid", mid, 1);
    check("xf_concurrent", conc, 1);
    check("xf_l0", lvl(0), 0);
    check("xf_l1", lvl(1), 15);
    check("xf_fade_end", fading, 0);
    check("xf_out", led_out, 2);

    do_reset();
    led_in = 2'b10;
    wait_lvl(1, 9, "mid");
    rst = 1'b1;
    cyc(1);
    check("mid_level", lvl(1), 0);
    check("mid_out", led_out, 0);
    check("mid_fade", fading, 0);
    rst = 1'b0;
    cyc(3);
    check("mid_restart_hold", lvl(1), 0);
    check("mid_restart_fade", fading, 1);
    cyc(1);
    check("mid_restart_step", lvl(1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
